bcd_sub_serial: RTL and testbench
=================================

Name: bcd_sub_serial

Overview:
Digit-serial multi-digit BCD subtractor computing diff = a - b. It processes one BCD digit per clock, least significant digit first, with a borrow chain. It is the subtraction counterpart of the BCD adder datapath. A start/busy/done handshake lets a controller reuse a single digit-subtract slice over DIGITS cycles.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  subtrahend, packed BCD.
busy  output  1  high while in RUN (and in NEG when the feature is enabled).
done  output  1  one-cycle pulse when the result is valid.
diff  output  4*DIGITS  registered result; holds until the next done.
borrow_out  output  1  final borrow; 1 means a < b.
neg  output  1  result sign (see Optional Feature).
invalid  output  1  any input nibble >9 in the latched a or b.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE; busy=0, done=0, diff=0, borrow_out=0, neg=0, invalid=0; internal operand shift registers, borrow and digit counter all 0.
- FSM states: IDLE, RUN, DONE (plus NEG when the feature is enabled).
- IDLE:
  - If start=1 at an edge, latch a and b into shift registers.
  - Clear internal borrow and counter, compute invalid from the latched operands, and go to RUN.
- RUN, each edge:
  - Digit op: t = {1'b0,a_i} - {1'b0,b_i} - borrow (5-bit two's complement).
  - If t is negative: digit = (t+10)[3:0] and borrow=1. Otherwise digit = t[3:0] and borrow=0.
  - Shift the digit into the top of the result register and shift both operands right by 4. Increment the counter.
  - After the DIGITS-th RUN edge: go to DONE, load diff and borrow_out, and assert done.
- Latency: done is high in the cycle following the edge that is exactly DIGITS edges after the start-sampling edge. done lasts exactly one cycle.
- DONE: the next edge returns to IDLE. Outputs diff, borrow_out, neg and invalid hold until the next done.
- start is ignored in RUN, NEG and DONE; there is no queueing. A start asserted in the same cycle as done is dropped.
- Out-of-range digits: the same arithmetic applies unmodified. The result is defined but not meaningful; invalid flags it.
- a < b: diff is the 10^DIGITS complement and borrow_out=1.
- Asynchronous reset mid-operation aborts immediately and forces all reset values. No done pulse is produced.

Optional Feature:
- Macro: BCD_SUB_SIGNMAG_EN.
- Enabled:
  - If the RUN pass ends with borrow=1, enter NEG instead of DONE.
  - NEG computes 0 - result over DIGITS cycles with the same digit op, producing the magnitude.
  - neg=1 and diff holds the magnitude. Total latency becomes 2*DIGITS edges; busy stays high through NEG.
  - If borrow=0 at the end of RUN, go to DONE with latency DIGITS edges and neg=0.
- Disabled: NEG state absent, neg tied 0, diff is always the 10's complement form.

Test Plan:
- DIGITS=4, a=0x5432, b=0x1234, pulse start -> after 4 edges: done=1 for one cycle, diff=0x4198, borrow_out=0, invalid=0, busy high for 4 cycles.
- a=0x1000, b=0x0001 -> diff=0x0999 with the full borrow ripple, borrow_out=0.
- a=0x0000, b=0x0001:
  - Macro off -> diff=0x9999, borrow_out=1, neg=0.
  - Macro on -> after 8 edges diff=0x0001, neg=1, borrow_out=1.
- Start a=0x0007, b=0x0003; reassert start with a=0x9999 while busy -> single done with diff=0x0004; second request ignored, one done pulse only.
- a=0x00A0, b=0x0000 -> invalid=1 with done; diff=0x00A0-derived value per the digit op, no hang.
- Start an operation, deassert rst_n after 2 edges -> all outputs 0 immediately, state IDLE, no done. After release, a new start with 0x0010-0x0009 gives diff=0x0001.

Source files
------------

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: diff = a - b, one digit per clock, least significant digit first.
// Define BCD_SUB_SIGNMAG_EN to add a NEG pass that turns a borrowed result into sign + magnitude.
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                borrow_out,
    output logic                neg,
    output logic                invalid
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_SUB_SIGNMAG_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_NEG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    // One digit slice: returns {borrow_out, digit}; out-of-range nibbles pass through unmodified.
    function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y,
                                             input logic bin);
        logic [4:0] t;
        logic [4:0] u;
        t = {1'b0, x} - {1'b0, y} - {4'b0, bin};
        u = t + 5'd10;
        return t[4] ? {1'b1, u[3:0]} : {1'b0, t[3:0]};
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d, inv_q, inv_d;
    logic            bout_q, bout_d, neg_q, neg_d, invalid_q, invalid_d;

    logic [4:0]      step;
    logic [W-1:0]    res_n;
    logic            last;

    assign step  = digit_sub(a_q[3:0], b_q[3:0], borrow_q);
    assign res_n = (W'(step[3:0]) << (W - 4)) | (res_q >> 4);
    assign last  = (cnt_q == CW'(DIGITS - 1));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        inv_d     = inv_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        neg_d     = neg_q;
        invalid_d = invalid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    inv_d    = has_bad_digit(a) | has_bad_digit(b);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                res_d    = res_n;
                borrow_d = step[4];
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
`ifdef BCD_SUB_SIGNMAG_EN
                    // Borrowed result is in 10's complement; re-run the slice as 0 - result.
                    if (step[4]) begin
                        state_d  = S_NEG;
                        a_d      = '0;
                        b_d      = res_n;
                        borrow_d = 1'b0;
                    end else
`endif
                    begin
                        state_d   = S_DONE;
                        diff_d    = res_n;
                        bout_d    = step[4];
                        neg_d     = 1'b0;
                        invalid_d = inv_q;
                    end
                end
            end
`ifdef BCD_SUB_SIGNMAG_EN
            S_NEG: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                res_d    = res_n;
                borrow_d = step[4];
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    cnt_d     = '0;
                    state_d   = S_DONE;
                    diff_d    = res_n;
                    bout_d    = 1'b1;
                    neg_d     = 1'b1;
                    invalid_d = inv_q;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            inv_q     <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            inv_q     <= inv_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            neg_q     <= neg_d;
            invalid_q <= invalid_d;
        end
    end

`ifdef BCD_SUB_SIGNMAG_EN
    assign busy = (state_q == S_RUN) || (state_q == S_NEG);
`else
    assign busy = (state_q == S_RUN);
`endif
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign neg        = neg_q;
    assign invalid    = invalid_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial: decimal-arithmetic model checked every cycle,
// plus literal expectations on each completed operation.
module tb_bcd_sub_serial;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out, neg, invalid;
    logic [W-1:0] diff;

    bcd_sub_serial #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
        .neg(neg), .invalid(invalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Model state: one outstanding request plus the values the outputs currently hold.
    bit           pend = 1'b0;
    int           done_at = 0, busy_from = 0, idle_from = 0;
    logic [W-1:0] e_diff = '0, h_diff = '0;
    logic         e_bor = 0, e_neg = 0, e_inv = 0;
    logic         h_bor = 0, h_neg = 0, h_inv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int x);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        bit r = 0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1;
        return r;
    endfunction

    // Raw per-digit rule, only used when nibbles are out of range and decimal values are undefined.
    function automatic logic [W-1:0] digit_rule(input logic [W-1:0] x, input logic [W-1:0] y,
                                                output logic bor);
        logic [W-1:0] r = '0;
        int t;
        bor = 0;
        for (int i = 0; i < D; i++) begin
            t = int'(x[4*i +: 4]) - int'(y[4*i +: 4]) - int'(bor);
            bor = (t < 0);
            if (t < 0) t = t + 10;
            r[4*i +: 4] = 4'(t & 15);
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic bor, output logic ng,
                         output logic inv, output int lat);
        int pw = 1;
        int va, vb;
        logic dummy;
        for (int i = 0; i < D; i++) pw = pw * 10;
        va  = to_int(x);
        vb  = to_int(y);
        inv = has_bad(x) | has_bad(y);
        if (!inv) begin
            bor = (va < vb);
            r   = to_bcd(bor ? va - vb + pw : va - vb);
        end else begin
            r = digit_rule(x, y, bor);
        end
        ng  = 1'b0;
        lat = D;
`ifdef BCD_SUB_SIGNMAG_EN
        if (bor) begin
            ng  = 1'b1;
            lat = 2 * D;
            r   = inv ? digit_rule('0, r, dummy) : to_bcd(vb - va);
        end
`endif
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic exp_done;
        exp_done = 1'b0;
        if (pend && edge_cnt == done_at) begin
            h_diff = e_diff; h_bor = e_bor; h_neg = e_neg; h_inv = e_inv;
            pend = 1'b0;
            idle_from = done_at + 1;
            exp_done = 1'b1;
        end
        check("cyc_done", 32'(done), 32'(exp_done));
        check("cyc_busy", 32'(busy), 32'(pend && edge_cnt >= busy_from));
        check("cyc_diff", 32'(diff), 32'(h_diff));
        check("cyc_borrow_out", 32'(borrow_out), 32'(h_bor));
        check("cyc_neg", 32'(neg), 32'(h_neg));
        check("cyc_invalid", 32'(invalid), 32'(h_inv));
    end

    // Drive a start for one cycle starting now; the model accepts it only if the FSM is idle.
    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        #1;
        a = x;
        b = y;
        start = 1'b1;
        if (!pend && edge_cnt >= idle_from) begin
            model(x, y, e_diff, e_bor, e_neg, e_inv, lat);
            pend      = 1'b1;
            busy_from = edge_cnt + 1;
            done_at   = edge_cnt + 1 + lat;
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        drive_start(x, y);
    endtask

    task automatic wait_done(input string name, input logic [W-1:0] exp_diff,
                             input logic exp_bor, input logic exp_neg);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_diff"}, 32'(diff), 32'(exp_diff));
            check({name, "_borrow_out"}, 32'(borrow_out), 32'(exp_bor));
            check({name, "_neg"}, 32'(neg), 32'(exp_neg));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;

        pulse_start(16'h5432, 16'h1234);
        wait_done("t1", 16'h4198, 1'b0, 1'b0);
        check("t1_invalid", 32'(invalid), 32'd0);

        pulse_start(16'h1000, 16'h0001);
        wait_done("t2", 16'h0999, 1'b0, 1'b0);

`ifdef BCD_SUB_SIGNMAG_EN
        pulse_start(16'h0000, 16'h0001);
        wait_done("t3", 16'h0001, 1'b1, 1'b1);
        pulse_start(16'h1234, 16'h5678);
        wait_done("t3b", 16'h4444, 1'b1, 1'b1);
        pulse_start(16'h0000, 16'h9999);
        wait_done("t3c", 16'h9999, 1'b1, 1'b1);
`else
        pulse_start(16'h0000, 16'h0001);
        wait_done("t3", 16'h9999, 1'b1, 1'b0);
        pulse_start(16'h1234, 16'h5678);
        wait_done("t3b", 16'h5556, 1'b1, 1'b0);
        pulse_start(16'h0000, 16'h9999);
        wait_done("t3c", 16'h0001, 1'b1, 1'b0);
`endif

        pulse_start(16'h9999, 16'h9999);
        wait_done("t3d", 16'h0000, 1'b0, 1'b0);

        // Start while busy and start in the done cycle must both be dropped.
        pulse_start(16'h0007, 16'h0003);
        pulse_start(16'h9999, 16'h0000);
        wait_done("t4", 16'h0004, 1'b0, 1'b0);
        drive_start(16'h1111, 16'h0000);
        repeat (12) @(negedge clk);
        check("t4_hold_diff", 32'(diff), 32'h0004);

        pulse_start(16'h00A0, 16'h0000);
        wait_done("t5", 16'h00A0, 1'b0, 1'b0);
        check("t5_invalid", 32'(invalid), 32'd1);

        // Asynchronous reset two edges into an operation.
        pulse_start(16'h1234, 16'h0001);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        pend = 1'b0;
        idle_from = 0;
        h_diff = '0; h_bor = 0; h_neg = 0; h_inv = 0;
        #1;
        check("t6_rst_diff", 32'(diff), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);

        pulse_start(16'h0010, 16'h0009);
        wait_done("t7", 16'h0001, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
